// File: rtl/riscv_mem_arbiter.sv
// Arbitrates instruction fetch and load/store traffic onto one single-ported memory.
// Optional fetch anti-starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module riscv_mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   // fetch requester
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic                    if_gnt,
   output logic                    if_valid,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   output logic                    if_err,
   // load/store requester
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_be,
   output logic                    d_gnt,
   output logic                    d_valid,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    d_err,
   // memory port
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   input  logic                    mem_ready,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    busy
);

   localparam int TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [TO_WIDTH-1:0] to_cnt;
   logic                timeout;
   logic                fetch_forced;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int SC_WIDTH = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   logic [SC_WIDTH-1:0] starve_cnt;

   // Once fetch has lost STARVE_LIMIT arbitrations in a row, it wins the next one.
   assign fetch_forced = if_req && (starve_cnt == SC_WIDTH'(STARVE_LIMIT));

   always_ff @(posedge clk) begin
      if (reset)
         starve_cnt <= '0;
      else if (if_gnt)
         starve_cnt <= '0;
      else if (d_gnt && if_req && (starve_cnt != SC_WIDTH'(STARVE_LIMIT)))
         starve_cnt <= starve_cnt + 1'b1;
   end
`else
   logic [31:0] unused_starve_limit;
   assign unused_starve_limit = 32'(STARVE_LIMIT);
   assign fetch_forced        = 1'b0;
`endif

   assign busy    = (state != IDLE);
   assign timeout = busy && !mem_ready && (to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));

   // NOTE: every output of this block gets a default before the case, so no
   // path through it can leave a value unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      case (state)
         IDLE: begin
            // No grant while reset is held keeps every output low during reset.
            if (!reset) begin
               if (d_req && !fetch_forced) begin
                  d_gnt     = 1'b1;
                  state_nxt = BUSY_D;
               end else if (if_req) begin
                  if_gnt    = 1'b1;
                  state_nxt = BUSY_IF;
               end
            end
         end
         BUSY_IF, BUSY_D: begin
            if (mem_ready || timeout)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         to_cnt    <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         if_valid  <= 1'b0;
         if_rdata  <= '0;
         if_err    <= 1'b0;
         d_valid   <= 1'b0;
         d_rdata   <= '0;
         d_err     <= 1'b0;
      end else begin
         state    <= state_nxt;
         if_valid <= 1'b0;
         if_err   <= 1'b0;
         d_valid  <= 1'b0;
         d_err    <= 1'b0;
         if (d_gnt) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
            to_cnt    <= '0;
         end else if (if_gnt) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
            to_cnt    <= '0;
         end else if (busy) begin
            if (!mem_ready)
               to_cnt <= to_cnt + 1'b1;
            // A ready arriving together with the timeout is a normal completion.
            if (mem_ready || timeout) begin
               mem_req <= 1'b0;
               if (state == BUSY_IF) begin
                  if_valid <= 1'b1;
                  if_err   <= !mem_ready;
                  if_rdata <= mem_ready ? mem_rdata : '0;
               end else begin
                  d_valid <= 1'b1;
                  d_err   <= !mem_ready;
                  d_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: vector table plus scoreboard of completions,
// with a responding memory model and hand-written arbitration/reset sequences.
module tb_riscv_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int TO = 8;
   localparam int SL = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_gnt, if_valid, if_err;
   logic [DW-1:0] if_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [BW-1:0] d_be = '0;
   logic          d_gnt, d_valid, d_err;
   logic [DW-1:0] d_rdata;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [BW-1:0] mem_be;
   logic          mem_ready = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          busy;

   riscv_mem_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
      .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // One access: stimulus, memory behaviour (wait_n < 0 = never ready) and expectations.
   typedef struct {
      bit          fetch;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          wait_n;
      logic [31:0] resp;
      logic [31:0] exp_rdata;
      bit          exp_err;
      int          exp_lat;
      logic [3:0]  exp_mem_be;
   } vec_t;

   typedef struct {
      bit          fetch;
      logic [31:0] rdata;
      bit          err;
      int          lat;
      int          gnt_cyc;
   } sb_t;

   int          errors = 0;
   int          checks = 0;
   sb_t         sb_q[$];
   sb_t         mon_e;
   vec_t        pend_d, pend_if, act;
   bit          act_valid = 1'b0;
   int          cyc = 0;
   int          mcnt = 0;
   int          run_len = 0;
   int          last_run = 0;
   int          n_d_gnt = 0;
   int          n_if_gnt = 0;
   int          n_valid = 0;
   int          last_if_gnt_cyc = -1;
   int          last_d_valid_cyc = -2;
   logic [31:0] last_if_rdata = '0;
   logic [31:0] last_d_rdata = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic vec_t mk(input bit fetch, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input int w, input logic [31:0] resp);
      vec_t v;
      v.fetch      = fetch;
      v.we         = fetch ? 1'b0 : we;
      v.addr       = addr;
      v.wdata      = wdata;
      v.be         = be;
      v.wait_n     = w;
      v.resp       = resp;
      v.exp_rdata  = (w < 0 || v.we) ? 32'h0 : resp;
      v.exp_err    = (w < 0);
      v.exp_lat    = (w < 0) ? TO + 1 : w + 2;
      v.exp_mem_be = fetch ? 4'hF : be;
      return v;
   endfunction

   // Monitor, memory model and scoreboard, all evaluated away from the active edge.
   always @(negedge clk) begin
      cyc++;
      if (if_valid || d_valid) begin
         n_valid++;
         check("valid_exclusive", 32'(if_valid & d_valid), 32'h0);
         if (sb_q.size() == 0) begin
            check("unexpected_valid", 32'h1, 32'h0);
         end else begin
            mon_e = sb_q.pop_front();
            check("valid_side", 32'(if_valid), 32'(mon_e.fetch));
            check("latency", 32'(cyc - mon_e.gnt_cyc), 32'(mon_e.lat));
            if (if_valid) begin
               check("if_rdata", if_rdata, mon_e.rdata);
               check("if_err", 32'(if_err), 32'(mon_e.err));
               check("d_rdata_hold", d_rdata, last_d_rdata);
               last_if_rdata = mon_e.rdata;
            end else begin
               check("d_rdata", d_rdata, mon_e.rdata);
               check("d_err", 32'(d_err), 32'(mon_e.err));
               check("if_rdata_hold", if_rdata, last_if_rdata);
               last_d_rdata = mon_e.rdata;
            end
         end
         if (d_valid) last_d_valid_cyc = cyc;
      end

      if (mem_req === 1'b1) begin
         if (!act_valid) begin
            check("mem_req_without_grant", 32'h1, 32'h0);
         end else begin
            check("busy", 32'(busy), 32'h1);
            check("mem_addr", mem_addr, act.addr);
            check("mem_we", 32'(mem_we), 32'(act.we));
            check("mem_be", 32'(mem_be), 32'(act.exp_mem_be));
            if (!act.fetch) check("mem_wdata", mem_wdata, act.wdata);
         end
         mem_ready = act_valid && (act.wait_n >= 0) && (mcnt == act.wait_n);
         mem_rdata = mem_ready ? act.resp : $urandom;
         mcnt++;
         run_len++;
      end else begin
         if (run_len != 0) last_run = run_len;
         run_len   = 0;
         mcnt      = 0;
         mem_ready = 1'b0;
         mem_rdata = $urandom;
      end

      if (d_gnt === 1'b1 && if_gnt === 1'b1) check("dual_grant", 32'h1, 32'h0);
      if (d_gnt === 1'b1) begin
         check("d_gnt_while_req", 32'(d_req), 32'h1);
         act = pend_d;
         act_valid = 1'b1;
         sb_q.push_back('{1'b0, act.exp_rdata, act.exp_err, act.exp_lat, cyc});
         n_d_gnt++;
      end else if (if_gnt === 1'b1) begin
         check("if_gnt_while_req", 32'(if_req), 32'h1);
         act = pend_if;
         act_valid = 1'b1;
         sb_q.push_back('{1'b1, act.exp_rdata, act.exp_err, act.exp_lat, cyc});
         n_if_gnt++;
         last_if_gnt_cyc = cyc;
      end

      // Reset abandons whatever was in flight; the model forgets it too.
      if (reset) begin
         sb_q.delete();
         act_valid     = 1'b0;
         last_if_rdata = '0;
         last_d_rdata  = '0;
      end
   end

   task automatic issue(input vec_t v);
      int base;
      int c;
      @(posedge clk); #1;
      if (v.fetch) begin
         pend_if = v;
         if_addr = v.addr;
         base    = n_if_gnt;
         if_req  = 1'b1;
      end else begin
         pend_d  = v;
         d_we    = v.we;
         d_addr  = v.addr;
         d_wdata = v.wdata;
         d_be    = v.be;
         base    = n_d_gnt;
         d_req   = 1'b1;
      end
      c = 0;
      while (((v.fetch ? n_if_gnt : n_d_gnt) == base) && c < 50) begin
         @(posedge clk); #1;
         c++;
      end
      check("grant_seen", 32'(c < 50), 32'h1);
      if (v.fetch) if_req = 1'b0;
      else d_req = 1'b0;
   endtask

   task automatic wait_done();
      int c = 0;
      while ((sb_q.size() != 0 || busy !== 1'b0) && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      check("completion_seen", 32'(c < 100), 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   vec_t tbl [8];
   int   base_d, base_if, base_v, c;

   initial begin
      //          fetch we    addr          wdata         be    wait resp          exp_rdata     err   lat mem_be
      tbl[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        4'h0, 0,  32'h0000_0013, 32'h0000_0013, 1'b0, 2, 4'hF};
      tbl[1] = '{1'b0, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'h3, 3,  32'hCAFE_F00D, 32'h0,         1'b0, 5, 4'h3};
      tbl[2] = '{1'b0, 1'b0, 32'h0000_3000, 32'h1111_1111, 4'hF, 1,  32'h1234_5678, 32'h1234_5678, 1'b0, 3, 4'hF};
      tbl[3] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,        4'h0, 2,  32'h00A0_0093, 32'h00A0_0093, 1'b0, 4, 4'hF};
      tbl[4] = '{1'b0, 1'b0, 32'h0000_3004, 32'h0,        4'hF, -1, 32'h0BAD_0BAD, 32'h0,         1'b1, 9, 4'hF};
      tbl[5] = '{1'b0, 1'b0, 32'h0000_3008, 32'h0,        4'hF, 0,  32'h55AA_55AA, 32'h55AA_55AA, 1'b0, 2, 4'hF};
      tbl[6] = '{1'b1, 1'b0, 32'h0000_0108, 32'h0,        4'h0, -1, 32'h0000_0073, 32'h0,         1'b1, 9, 4'hF};
      tbl[7] = '{1'b0, 1'b1, 32'h0000_300C, 32'h0102_0304, 4'hC, 0,  32'hFFFF_FFFF, 32'h0,         1'b0, 2, 4'hC};

      // Reset with a fetch request pending: nothing may be granted or driven.
      reset  = 1'b1;
      if_req = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      check("reset_ctrl", 32'({if_gnt, d_gnt, if_valid, d_valid, if_err, d_err, mem_req, mem_we, busy}), 32'h0);
      check("reset_mem_addr", mem_addr, 32'h0);
      check("reset_mem_be", 32'(mem_be), 32'h0);
      check("reset_rdata", if_rdata | d_rdata, 32'h0);
      if_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         issue(tbl[i]);
         wait_done();
         check("mem_req_cycles", 32'(last_run), 32'((tbl[i].wait_n < 0) ? TO : tbl[i].wait_n + 1));
      end

      // Simultaneous requests: data first, fetch granted as d_valid pulses.
      fork
         issue(mk(1'b0, 1'b0, 32'h0000_4000, 32'h0, 4'hF, 0, 32'hA5A5_0001));
         issue(mk(1'b1, 1'b0, 32'h0000_010C, 32'h0, 4'h0, 0, 32'h0000_0513));
      join
      wait_done();
      check("if_gnt_on_d_valid", 32'(last_if_gnt_cyc), 32'(last_d_valid_cyc));

      // Reset on the second busy cycle of an access the memory never answers.
      base_v = n_valid;
      issue(mk(1'b0, 1'b0, 32'h0000_5000, 32'h0, 4'hF, -1, 32'h0));
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      #2;
      check("rst_busy_ctrl", 32'({if_gnt, d_gnt, if_valid, d_valid, if_err, d_err, mem_req, mem_we, busy}), 32'h0);
      check("rst_busy_mem_addr", mem_addr, 32'h0);
      check("rst_busy_rdata", if_rdata | d_rdata, 32'h0);
      repeat (12) @(posedge clk);
      #1;
      check("rst_busy_no_valid", 32'(n_valid - base_v), 32'h0);

      // Continuous data traffic against a waiting fetch.
      pend_d  = mk(1'b0, 1'b0, 32'h0000_6000, 32'h0, 4'hF, 0, 32'h6666_0000);
      pend_if = mk(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 0, 32'h0000_0013);
      @(posedge clk); #1;
      d_we    = 1'b0;
      d_addr  = 32'h0000_6000;
      d_be    = 4'hF;
      if_addr = 32'h0000_0200;
      base_d  = n_d_gnt;
      base_if = n_if_gnt;
      d_req   = 1'b1;
      if_req  = 1'b1;
      c = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      while (n_if_gnt == base_if && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      check("starve_fetch_granted", 32'(c < 100), 32'h1);
      check("starve_data_grants", 32'(n_d_gnt - base_d), 32'(SL));
`else
      while ((n_d_gnt - base_d) < 8 && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      d_req = 1'b0;
      check("strict_data_grants", 32'(n_d_gnt - base_d), 32'h8);
      check("strict_fetch_waits", 32'(n_if_gnt - base_if), 32'h0);
      c = 0;
      while (n_if_gnt == base_if && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      if_req = 1'b0;
      check("strict_fetch_after_drop", 32'(c < 100), 32'h1);
`endif
      wait_done();

      // A plain access after all of the above still completes normally.
      issue(mk(1'b0, 1'b0, 32'h0000_7000, 32'h0, 4'hF, 2, 32'h7777_0007));
      wait_done();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
